// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready on both sides and an optional iterative MUL.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier; otherwise op 110 reports illegal.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW:0] WidthVal = (SHW + 1)'(WIDTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StDone = 2'd2;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [1:0] StExec = 2'd1;
`endif

    localparam logic [2:0] OpXor = 3'b000;
    localparam logic [2:0] OpEq  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;
    localparam logic [2:0] OpSub = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpRor = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW:0]       cnt_q, cnt_d;
`endif

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   amt;
    logic [SHW:0]     amt_inv;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_illegal;

    assign in_ready = !Reset && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    assign accept   = in_valid && in_ready;

    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign illegal   = illegal_q;

    // Rotates use a complementary shift; amount 0 makes the second shift WIDTH, which yields 0.
    assign amt     = b[SHW-1:0];
    assign amt_inv = WidthVal - {1'b0, amt};
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
        case (op)
            OpXor: alu_res = a ^ b;
            OpEq:  alu_res = {{(WIDTH - 1){1'b0}}, (a != b)};
            OpAdd: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OpAnd: alu_res = a & b;
            OpRol: alu_res = (a << amt) | (a >> amt_inv);
            OpSub: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            OpMul: begin
`ifndef SEQ_ALU_MUL_EN
                alu_res     = '1;
                alu_illegal = 1'b1;
`endif
            end
            OpRor: alu_res = (a >> amt) | (a << amt_inv);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
`ifdef SEQ_ALU_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                    if (op == OpMul) begin
                        state_d  = StExec;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else
`endif
                    begin
                        state_d   = StDone;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        carry_d   = alu_carry;
                        illegal_d = alu_illegal;
                    end
                end
            end
`ifdef SEQ_ALU_MUL_EN
            StExec: begin
                // WIDTH add-and-shift iterations, then one cycle to publish the product.
                if (cnt_q != WidthVal) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + {{SHW{1'b0}}, 1'b1};
                end else begin
                    state_d   = StDone;
                    result_d  = acc_q[WIDTH-1:0];
                    zero_d    = (acc_q[WIDTH-1:0] == '0);
                    carry_d   = |acc_q[2*WIDTH-1:WIDTH];
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
`ifdef SEQ_ALU_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU for the datapath. Generalises the 8-bit combinational ALU to WIDTH bits.
- Adds SUB, ROR and an iterative shift-add MUL, plus a carry/borrow flag.
- Sits between the register file read stage and writeback.
- Uses a valid/ready handshake on both sides, so the controller can stall on multi-cycle MUL.

Parameters:
- WIDTH, 8, datapath width in bits; must be ≥ 2 and a power of two.
- SHW, $clog2(WIDTH), derived localparam (not overridable): rotate-amount bits taken from b.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- op  in  3  opcode: 000 XOR, 001 EQ, 010 ADD, 011 AND, 100 ROL, 101 SUB, 110 MUL, 111 ROR.
- a  in  WIDTH  operand 1.
- b  in  WIDTH  operand 2 / rotate amount.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes result; transfer when out_valid && out_ready.
- result  out  WIDTH  registered result.
- zero  out  1  registered: result == 0.
- carry  out  1  registered: ADD carry-out, SUB borrow, MUL overflow, else 0.
- illegal  out  1  registered: op not supported in this build.

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high.
- Reset state: FSM IDLE; out_valid=0, result=0, zero=0, carry=0, illegal=0, MUL counter=0.
- Reset during EXEC or DONE: the operation is aborted and the result is discarded.
- in_ready while Reset is high: 0 (combinational gate).
- FSM states: IDLE, EXEC (MUL only), DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back single-cycle ops at one per cycle.
- Accepting a single-cycle op: result, zero, carry and illegal are registered on the accept edge. State goes to DONE, and out_valid=1 the next cycle (latency 1).
- Accepting MUL: a, b and op are latched, the accumulator is cleared, and state goes to EXEC.
  - EXEC runs WIDTH iterations, one multiplier bit per cycle: add the shifted multiplicand, then shift.
  - After the last iteration, state goes to DONE. out_valid rises WIDTH+1 cycles after the accept edge.
  - in_valid is ignored during EXEC.
- DONE without out_ready: outputs hold stable and state stays DONE.
- DONE with out_ready and no new accept: state goes to IDLE and out_valid falls.
- DONE with out_ready and a simultaneous accept: the new op's result replaces the old one (single-cycle op, stays in DONE) or state goes to EXEC (MUL, out_valid falls).
- XOR/AND: bitwise.
- EQ: result = 0 if a==b, else 1 (branch compare). zero follows the result.
- ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
- SUB: result = (a−b) mod 2^WIDTH; carry = 1 iff a < b unsigned (borrow).
- ROL/ROR: rotate a by b[SHW-1:0] positions, no data loss; amount 0 passes a. The upper bits of b are ignored.
- MUL: unsigned. result = low WIDTH bits of a*b; carry = OR of the high WIDTH bits (overflow).
- zero is always computed on the registered result, never on stale data.

Optional Feature:
- Macro: SEQ_ALU_MUL_EN.
- Defined: MUL is implemented as above (EXEC state, counter, accumulator).
- Undefined:
  - No EXEC state or MUL hardware.
  - op 110 is accepted as a single-cycle op with result = all ones, carry=0, zero=0, illegal=1, latency 1.
  - All other ops are unchanged. illegal is 0 for every other op in both builds.

Test Plan:
- Reset with in_valid=1 held → in_ready=0 while Reset=1; after release, out_valid=0 and result=0.
- WIDTH=8: ADD a=0xF0, b=0x20 → one cycle later out_valid=1, result=0x10, carry=1, zero=0. Hold out_ready=0 for 5 cycles → outputs stable.
- WIDTH=8: SUB a=0x05, b=0x05 → result=0x00, zero=1, carry=0. Then EQ a=3, b=4 back-to-back with out_ready=1 → result=0x01, zero=0, no idle cycle between transfers.
- WIDTH=8: ROL a=0x81, b=0x09 → result=0x03 (amount 1). ROR a=0x81, b=0x03 → result=0x30.
- MUL_EN, WIDTH=8: MUL a=0x10, b=0x11 → in_ready=0 during EXEC; out_valid exactly 9 cycles after accept; result=0x10, carry=1. Assert Reset mid-EXEC → IDLE, out_valid=0.
- MUL_EN undefined: op=110 → result=0xFF, illegal=1, latency 1. WIDTH=16 ADD 0xFFFF+0x0001 → result=0x0000, carry=1, zero=1.
